// File: rtl/pad_stream_pkg.sv
// pad_stream_pkg: shared beat type and width defaults for the pad stream receiver
package pad_stream_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } beat_t;
endpackage

// File: rtl/stream_sync_fifo.sv
// stream_sync_fifo: show-ahead synchronous FIFO with occupancy count
module stream_sync_fifo
  import pad_stream_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign valid_o = count_q != '0;
  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
  assign do_pop = pop_i && valid_o;
  assign data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
  always_comb count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/pad_stream_rx.sv
// pad_stream_rx: pad input register, show-ahead FIFO and registered ready; frame checker under PAD_STREAM_RX_FRAME_CHECK_EN
module pad_stream_rx
  import pad_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 8,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              pad_valid_i,
  input  logic              pad_last_i,
  input  logic [DATA_W-1:0] pad_data_i,
  output logic              pad_ready_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [LW-1:0]     level_o,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  frame_ok_cnt_o,
  output logic [CNT_W-1:0]  frame_err_cnt_o,
  output logic              frame_err_o
);
  logic in_v_q, in_v_d, in_last_q, pad_ready_q, pad_ready_d, pop;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W:0] head;
  logic [LW-1:0] fifo_cnt, cnt_next, occ_next;
  assign pop = m_valid_o & m_ready_i;
  assign in_v_d = pad_valid_i & pad_ready_q;
  // ready looks one beat ahead so the input register always finds room
  always_comb begin
    cnt_next = fifo_cnt + LW'(in_v_q) - LW'(pop);
    occ_next = cnt_next + LW'(in_v_d);
    pad_ready_d = occ_next <= LW'(DEPTH - 2);
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      in_v_q <= 1'b0;
      in_last_q <= 1'b0;
      in_data_q <= '0;
      pad_ready_q <= 1'b0;
    end else begin
      in_v_q <= in_v_d;
      if (in_v_d) {in_last_q, in_data_q} <= {pad_last_i, pad_data_i};
      pad_ready_q <= pad_ready_d;
    end
  stream_sync_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .push_i  (in_v_q),
    .data_i  ({in_last_q, in_data_q}),
    .pop_i   (pop),
    .valid_o (m_valid_o),
    .data_o  (head),
    .count_o (fifo_cnt)
  );
  assign {m_last_o, m_data_o} = head;
  assign pad_ready_o = pad_ready_q;
  assign level_o = fifo_cnt + LW'(in_v_q);
`ifdef PAD_STREAM_RX_FRAME_CHECK_EN
  localparam int BW = $clog2(FRAME_LEN + 1);
  logic [BW-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] ok_q, ok_d, err_q, err_d;
  logic err_flag_q, err_flag_d, full_len, frame_end, err_hit;
  always_comb begin
    full_len = (beat_q + BW'(1)) == BW'(FRAME_LEN);
    frame_end = in_v_q && (in_last_q || full_len);
    err_hit = frame_end && !(in_last_q && full_len);
    beat_d = frame_end ? '0 : beat_q + BW'(in_v_q);
    ok_d = clear_i ? '0 : ok_q + CNT_W'(frame_end && !err_hit);
    err_d = clear_i ? '0 : err_q + CNT_W'(err_hit && err_q != '1);
    err_flag_d = !clear_i && (err_flag_q || err_hit);
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      beat_q <= '0;
      ok_q <= '0;
      err_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ok_q <= ok_d;
      err_q <= err_d;
      err_flag_q <= err_flag_d;
    end
  assign frame_ok_cnt_o = ok_q;
  assign frame_err_cnt_o = err_q;
  assign frame_err_o = err_flag_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i | (FRAME_LEN < 1);
  assign frame_ok_cnt_o = '0;
  assign frame_err_cnt_o = '0;
  assign frame_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pad_stream_rx.sv
// tb_pad_stream_rx: queue-based reference model with per-cycle compare plus literal pins
module tb_pad_stream_rx;
  localparam int DW = 8, DEPTH = 8, FL = 4, CW = 16, LW = $clog2(DEPTH) + 1;
`ifdef PAD_STREAM_RX_FRAME_CHECK_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, pad_valid = 0, pad_last = 0, m_ready = 0, clear = 0;
  logic [DW-1:0] pad_data = 0;
  logic pad_ready, m_valid, m_last, frame_err;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;
  logic [CW-1:0] ok_cnt, err_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pad_stream_rx #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .pad_valid_i     (pad_valid),
    .pad_last_i      (pad_last),
    .pad_data_i      (pad_data),
    .pad_ready_o     (pad_ready),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_data_o        (m_data),
    .m_last_o        (m_last),
    .level_o         (level),
    .clear_i         (clear),
    .frame_ok_cnt_o  (ok_cnt),
    .frame_err_cnt_o (err_cnt),
    .frame_err_o     (frame_err)
  );

  typedef struct {logic [DW-1:0] data; logic last; int avail;} ent_t;
  ent_t q[$];
  int cyc = 0, n_acc = 0;
  bit live = 0, do_acc = 0, do_pop = 0;
  int m_ok = 0, m_err = 0, m_bc = 0;
  bit m_flag = 0;
  logic [DW-1:0] pop_data[$], acc_data[$];
  int pop_cyc[$], acc_cyc[$];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // frame rules applied to the accepted beat sequence
  task automatic frame_model(bit last);
    m_bc++;
    if (last || m_bc == FL) begin
      if (last && m_bc == FL) m_ok++;
      else begin
        if (m_err < 65535) m_err++;
        m_flag = 1;
      end
      m_bc = 0;
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    bit ev;
    ev = q.size() > 0 && q[0].avail <= cyc;
    chk("m_valid", m_valid, ev);
    if (ev && m_valid) begin
      chk("m_data", m_data, q[0].data);
      chk("m_last", m_last, q[0].last);
    end
    chk("level", level, q.size());
    chk("pad_ready", pad_ready, live && q.size() <= DEPTH - 2);
    do_acc = pad_valid && pad_ready;
    do_pop = m_valid && m_ready && q.size() > 0;
  end

  always @(posedge clk) if (rst_n) begin
    cyc++;
    live = 1;
    if (do_pop) begin
      pop_data.push_back(q[0].data);
      pop_cyc.push_back(cyc);
      void'(q.pop_front());
    end
    if (do_acc) begin
      q.push_back('{pad_data, pad_last, cyc + 1});
      acc_data.push_back(pad_data);
      acc_cyc.push_back(cyc);
      n_acc++;
      frame_model(pad_last);
    end
    do_acc = 0;
    do_pop = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_data.delete(); pop_cyc.delete(); acc_data.delete(); acc_cyc.delete();
  endtask

  task automatic drain(int max);
    int n = 0;
    pad_valid = 0;
    pad_last = 0;
    m_ready = 1;
    while (q.size() > 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic chk_frames(string tag, int eok, int eerr, int eflag);
    chk({tag, "_ok"}, ok_cnt, eok);
    chk({tag, "_err"}, err_cnt, eerr);
    chk({tag, "_flag"}, frame_err, eflag);
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
    m_ok = 0; m_err = 0; m_flag = 0;
  endtask

  task automatic send(logic [DW-1:0] d, bit l);
    pad_valid = 1; pad_data = d; pad_last = l;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", pad_ready, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_level", level, 0);
    chk_frames("rst", 0, 0, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_before_edge", pad_ready, 0);
    tick();
    chk("ready_after_edge", pad_ready, 1);
    chk("idle_valid", m_valid, 0);
    chk("idle_level", level, 0);

    clear_logs();
    m_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      send(DW'(i), i == 16);
      chk("stream_ready", pad_ready, 1);
    end
    drain(50);
    chk("stream_count", pop_data.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("stream_byte", pop_data[i], i + 1);
      chk("stream_rate", pop_cyc[i], pop_cyc[0] + i);
    end
    chk("stream_latency", pop_cyc[0] - acc_cyc[0], 2);

    clear_logs();
    m_ready = 0;
    for (int i = 0; i < 12; i++) send(DW'(8'h40 + i), 0);
    chk("bp_level", level, 7);
    chk("bp_ready", pad_ready, 0);
    m_ready = 1;
    for (int i = 12; i < 32; i++) send(DW'(8'h40 + i), 0);
    drain(60);
    chk("bp_count", pop_data.size(), acc_data.size());
    for (int i = 0; i < acc_data.size(); i++) chk("bp_order", pop_data[i], acc_data[i]);

    m_ready = 0;
    for (int i = 0; i < 5; i++) send(DW'(8'hA0 + i), 0);
    pad_valid = 0;
    tick();
    chk("mid_level", level, 5);
    #2;
    rst_n = 0;
    q.delete(); live = 0; do_acc = 0; do_pop = 0;
    m_bc = 0; m_ok = 0; m_err = 0; m_flag = 0;
    #1;
    chk("mid_rst_ready", pad_ready, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_level", level, 0);
    repeat (2) tick();
    rst_n = 1;
    m_ready = 1;
    repeat (5) tick();
    chk("no_stale", m_valid, 0);

    foreach (pad_data[i]) ;
    for (int i = 0; i < 4; i++) send(DW'(i), i == 3);
    for (int i = 0; i < 3; i++) send(DW'(i), i == 2);
    for (int i = 0; i < 5; i++) send(DW'(i), i == 4);
    drain(40);
    chk_frames("frames", FC_EN ? 1 : 0, FC_EN ? 3 : 0, FC_EN ? 1 : 0);
    chk_frames("frames_model", FC_EN ? m_ok : 0, FC_EN ? m_err : 0, FC_EN ? m_flag : 0);
    pulse_clear();
    chk_frames("cleared", 0, 0, 0);

    clear_logs();
    n_acc = 0;
    for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
      pad_valid = $urandom_range(0, 9) < 7;
      pad_data = DW'($urandom);
      pad_last = $urandom_range(0, 7) == 0;
      m_ready = $urandom_range(0, 9) < 6;
      tick();
      if (level > DEPTH) chk("level_bound", level, DEPTH);
    end
    chk("rand_beats", n_acc, 10000);
    drain(60);
    chk("rand_count", pop_data.size(), acc_data.size());
    chk_frames("rand_frames", FC_EN ? m_ok : 0, FC_EN ? m_err : 0, FC_EN ? m_flag : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
